uart_cmd_controller: RTL

UART_CMD_CONTROLLER -- requirements
Module: uart_cmd_controller

---
 rtl/uart_cmd_pkg.sv | 25 ++
 rtl/uart_timeout_ctr.sv | 38 +++
 rtl/uart_cmd_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Purpose: shared state encoding, sync byte and command codes for the UART command controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_e;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_WRITE_W = 8'h01;
  localparam logic [7:0] CMD_WRITE_A = 8'h02;
  localparam logic [7:0] CMD_START   = 8'h03;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_WRITE_W) || (c == CMD_WRITE_A) || (c == CMD_START);
  endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// Purpose: counts consecutive idle clocks inside a packet and flags when the limit is reached.
// Latency: expired is combinational in the cycle the TIMEOUT_CYCLES-th idle clock is seen.
// Backpressure: none; clear has priority over enable.
// Ports: clk, rst_n; clear (restart count), enable (count this clock), expired (single-cycle flag).
module uart_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the idle clock that completes the run; the owner leaves the
  // busy states on that same edge, so the flag never lasts two cycles.
  assign expired = enable && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = expired ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_controller.sv
// Purpose: parses A5/CMD/ADDR/LEN/payload/CHK packets from a UART byte stream into buffer writes and a compute start.
// Latency: every write strobe and status pulse is registered, one cycle after the causing rx_valid.
// Backpressure: none; bytes are accepted whenever rx_valid pulses, idle gaps bounded by TIMEOUT_CYCLES.
// Ports: clk, rst_n; rx_valid/rx_data in; wr_en/wr_sel/wr_addr/wr_data, start, busy,
//        cmd_done, err_checksum, err_timeout, err_cmd out.
module uart_cmd_controller
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              start,
  output logic              busy,
  output logic              cmd_done,
  output logic              err_checksum,
  output logic              err_timeout,
  output logic              err_cmd
);

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        len_q, len_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              cmd_done_q, cmd_done_d;
  logic              err_checksum_q, err_checksum_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_cmd_q, err_cmd_d;

  logic tmo_clear, tmo_enable, tmo_expired;

  assign busy       = (state_q != S_SYNC);
  assign tmo_clear  = rx_valid || !busy;
  assign tmo_enable = busy && !rx_valid;

  uart_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    addr_hi_d      = addr_hi_q;
    chk_d          = chk_q;
    len_d          = len_q;
    wr_en_d        = 1'b0;
    wr_sel_d       = wr_sel_q;
    // wr_addr holds the address of the strobe currently on the bus, so it
    // steps forward on the cycle after each strobe; back-to-back bytes then
    // see the incremented address exactly when their own strobe goes out.
    wr_addr_d      = wr_en_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
    wr_data_d      = wr_data_q;
    start_d        = 1'b0;
    cmd_done_d     = 1'b0;
    err_checksum_d = 1'b0;
    err_timeout_d  = 1'b0;
    err_cmd_d      = 1'b0;

    // A byte arriving on the expiry clock wins over the timeout.
    if (rx_valid) begin
      case (state_q)
        S_SYNC: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_CMD;
            chk_d   = '0;
          end
        end
        S_CMD: begin
          if (cmd_known(rx_data)) begin
            cmd_d   = rx_data;
            chk_d   = chk_q ^ rx_data;
            state_d = S_ADDR_HI;
          end else begin
            err_cmd_d = 1'b1;
            state_d   = S_SYNC;
          end
        end
        S_ADDR_HI: begin
          addr_hi_d = rx_data;
          chk_d     = chk_q ^ rx_data;
          state_d   = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          // Truncates for narrow buffers, zero-extends for wide ones.
          wr_addr_d = ADDR_W'({addr_hi_q, rx_data});
          chk_d     = chk_q ^ rx_data;
          state_d   = S_LEN;
        end
        S_LEN: begin
          chk_d   = chk_q ^ rx_data;
          len_d   = rx_data;
          state_d = (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          chk_d = chk_q ^ rx_data;
          len_d = len_q - 8'd1;
          if (cmd_q != CMD_START) begin
            wr_en_d   = 1'b1;
            wr_data_d = rx_data;
            wr_sel_d  = cmd_q[1];
          end
          if (len_q == 8'd1) state_d = S_CHK;
        end
        S_CHK: begin
          if (rx_data == chk_q) begin
            cmd_done_d = 1'b1;
            start_d    = (cmd_q == CMD_START);
          end else begin
            err_checksum_d = 1'b1;
          end
          state_d = S_SYNC;
        end
        default: state_d = S_SYNC;
      endcase
    end else if (tmo_expired) begin
      err_timeout_d = 1'b1;
      state_d       = S_SYNC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_SYNC;
      cmd_q          <= '0;
      addr_hi_q      <= '0;
      chk_q          <= '0;
      len_q          <= '0;
      wr_en_q        <= 1'b0;
      wr_sel_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      start_q        <= 1'b0;
      cmd_done_q     <= 1'b0;
      err_checksum_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_cmd_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      addr_hi_q      <= addr_hi_d;
      chk_q          <= chk_d;
      len_q          <= len_d;
      wr_en_q        <= wr_en_d;
      wr_sel_q       <= wr_sel_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      start_q        <= start_d;
      cmd_done_q     <= cmd_done_d;
      err_checksum_q <= err_checksum_d;
      err_timeout_q  <= err_timeout_d;
      err_cmd_q      <= err_cmd_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_sel       = wr_sel_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign start        = start_q;
  assign cmd_done     = cmd_done_q;
  assign err_checksum = err_checksum_q;
  assign err_timeout  = err_timeout_q;
  assign err_cmd      = err_cmd_q;

endmodule
